// File: rtl/eth_pll_pkg.sv
// Shared types and default timing for the Ethernet PLL lock manager.
// The statistics counters are enabled by defining ETH_PLL_LOCK_STATS_EN.
package eth_pll_pkg;

    typedef enum logic [1:0] {
        ST_PLL_RESET = 2'd0,
        ST_WAIT_LOCK = 2'd1,
        ST_STABLE    = 2'd2,
        ST_RUN       = 2'd3
    } mgr_state_e;

    // Defaults for a 125 MHz reference clock
    localparam int DEF_RST_CYCLES    = 16;       // PLL reset pulse width
    localparam int DEF_LOCK_TIMEOUT  = 125000;   // 1 ms
    localparam int DEF_STABLE_CYCLES = 1250;     // 10 us
    localparam int DEF_CNT_W         = 17;       // shared timer width

    localparam int COUNT_W = 8;

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer with asynchronous active-low reset.
module sync_2ff #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] r_meta;
    logic [W-1:0] r_sync;

    // First flop may go metastable; second gives it a full cycle to settle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule

// File: rtl/eth_pll_lock_mgr.sv
// Ethernet PLL supervisor running on the free-running reference clock.
// Pulses the PLL reset, waits for a debounced lock, then releases the
// Ethernet domain reset; re-resets the PLL on lock loss, timeout or request.
// Define ETH_PLL_LOCK_STATS_EN to build the loss/retry counters; otherwise
// both count ports read zero and no counter flops exist.
module eth_pll_lock_mgr
    import eth_pll_pkg::*;
#(
    parameter int RST_CYCLES    = DEF_RST_CYCLES,
    parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic               refclk,
    input  logic               rst_n,
    input  logic               pll_locked,
    input  logic               force_relock,
    output logic               pll_rst,
    output logic               eth_rst_n,
    output logic               lock_ok,
    output logic [1:0]         mgr_state,
    output logic [COUNT_W-1:0] loss_count,
    output logic [COUNT_W-1:0] retry_count
);

    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);

    mgr_state_e       r_state;
    mgr_state_e       w_nxt;
    logic [CNT_W-1:0] r_timer;
    logic             r_pll_rst;
    logic             r_eth_rst_n;
    logic             r_lock_ok;
    logic             w_locked_s;
    logic             w_loss_evt;
    logic             w_retry_evt;

    sync_2ff #(.W(1)) u_lock_sync (
        .clk   (refclk),
        .rst_n (rst_n),
        .d     (pll_locked),
        .q     (w_locked_s)
    );

    // Next state; force_relock outranks everything except in PLL_RESET
    always_comb begin
        w_nxt       = r_state;
        w_loss_evt  = 1'b0;
        w_retry_evt = 1'b0;
        case (r_state)
            ST_PLL_RESET: begin
                if (r_timer == RST_LAST) w_nxt = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                if (force_relock)               w_nxt = ST_PLL_RESET;
                else if (w_locked_s)            w_nxt = ST_STABLE;
                else if (r_timer == TIMEOUT_LAST) begin
                    w_nxt       = ST_PLL_RESET;
                    w_retry_evt = 1'b1;
                end
            end
            ST_STABLE: begin
                if (force_relock)              w_nxt = ST_PLL_RESET;
                else if (!w_locked_s)          w_nxt = ST_WAIT_LOCK;
                else if (r_timer == STABLE_LAST) w_nxt = ST_RUN;
            end
            ST_RUN: begin
                // A real lock loss is counted even when a relock was also requested
                if (force_relock || !w_locked_s) w_nxt = ST_PLL_RESET;
                w_loss_evt = !w_locked_s;
            end
            default: w_nxt = ST_PLL_RESET;
        endcase
    end

    // State, shared timer and registered outputs derived from the next state
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_PLL_RESET;
            r_timer     <= '0;
            r_pll_rst   <= 1'b1;
            r_eth_rst_n <= 1'b0;
            r_lock_ok   <= 1'b0;
        end else begin
            r_state     <= w_nxt;
            if (w_nxt != r_state)      r_timer <= '0;
            else if (r_state != ST_RUN) r_timer <= r_timer + 1'b1;
            r_pll_rst   <= (w_nxt == ST_PLL_RESET);
            r_eth_rst_n <= (w_nxt == ST_RUN);
            r_lock_ok   <= (w_nxt == ST_RUN);
        end
    end

`ifdef ETH_PLL_LOCK_STATS_EN
    logic [COUNT_W-1:0] r_loss_cnt;
    logic [COUNT_W-1:0] r_retry_cnt;

    // Saturating event counters for field diagnostics
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            r_loss_cnt  <= '0;
            r_retry_cnt <= '0;
        end else begin
            if (w_loss_evt)  r_loss_cnt  <= sat_inc(r_loss_cnt);
            if (w_retry_evt) r_retry_cnt <= sat_inc(r_retry_cnt);
        end
    end

    assign loss_count  = r_loss_cnt;
    assign retry_count = r_retry_cnt;
`else
    logic w_unused_evt;
    assign w_unused_evt = w_loss_evt | w_retry_evt;
    assign loss_count   = '0;
    assign retry_count  = '0;
`endif

    assign pll_rst   = r_pll_rst;
    assign eth_rst_n = r_eth_rst_n;
    assign lock_ok   = r_lock_ok;
    assign mgr_state = r_state;

endmodule

// File: tb/tb_eth_pll_lock_mgr.sv
// Scoreboard bench for eth_pll_lock_mgr with short timing parameters.
// Expected counts follow ETH_PLL_LOCK_STATS_EN (zero when undefined).
module tb_eth_pll_lock_mgr;

    localparam int RST = 4;
    localparam int TO  = 20;
    localparam int STB = 8;
`ifdef ETH_PLL_LOCK_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic       refclk = 1'b0;
    logic       rst_n;
    logic       pll_locked;
    logic       force_relock;
    logic       pll_rst;
    logic       eth_rst_n;
    logic       lock_ok;
    logic [1:0] mgr_state;
    logic [7:0] loss_count;
    logic [7:0] retry_count;

    eth_pll_lock_mgr #(
        .RST_CYCLES    (RST),
        .LOCK_TIMEOUT  (TO),
        .STABLE_CYCLES (STB),
        .CNT_W         (17)
    ) dut (
        .refclk       (refclk),
        .rst_n        (rst_n),
        .pll_locked   (pll_locked),
        .force_relock (force_relock),
        .pll_rst      (pll_rst),
        .eth_rst_n    (eth_rst_n),
        .lock_ok      (lock_ok),
        .mgr_state    (mgr_state),
        .loss_count   (loss_count),
        .retry_count  (retry_count)
    );

    always #4 refclk = ~refclk;

    typedef struct packed {
        logic [1:0] st;
        logic       prst;
        logic       erst;
        logic       lok;
        logic [7:0] loss;
        logic [7:0] retry;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_bad = 0;

    // Reference model: state, timer, counts and the two sync stages
    int m_st, m_tmr, m_loss, m_retry;
    bit m_s1, m_s2;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ecnt(input int v);
        return STATS ? v : 0;
    endfunction

    task automatic model_reset();
        m_st = 0; m_tmr = 0; m_loss = 0; m_retry = 0; m_s1 = 0; m_s2 = 0;
    endtask

    task automatic go(input int s);
        m_st = s; m_tmr = 0;
    endtask

    // One refclk edge of the reference behaviour
    task automatic model_step();
        bit ls;
        ls   = m_s2;
        m_s2 = m_s1;
        m_s1 = pll_locked;
        case (m_st)
            0: if (m_tmr == RST - 1) go(1); else m_tmr++;
            1: begin
                if (force_relock) go(0);
                else if (ls) go(2);
                else if (m_tmr == TO - 1) begin
                    go(0);
                    if (m_retry < 255) m_retry++;
                end else m_tmr++;
            end
            2: begin
                if (force_relock) go(0);
                else if (!ls) go(1);
                else if (m_tmr == STB - 1) go(3);
                else m_tmr++;
            end
            default: begin
                if (!ls) begin
                    go(0);
                    if (m_loss < 255) m_loss++;
                end else if (force_relock) go(0);
            end
        endcase
    endtask

    function automatic exp_t exp_now();
        exp_t e;
        e.st    = 2'(m_st);
        e.prst  = (m_st == 0);
        e.erst  = (m_st == 3);
        e.lok   = (m_st == 3);
        e.loss  = 8'(ecnt(m_loss));
        e.retry = 8'(ecnt(m_retry));
        return e;
    endfunction

    // Advance one cycle: predict at the edge, compare on the falling edge
    task automatic tick();
        exp_t e;
        @(posedge refclk);
        if (rst_n) model_step(); else model_reset();
        sb.push_back(exp_now());
        @(negedge refclk);
        if (sb.size() == 0) begin
            chk("sb_underflow", 0, 1);
        end else begin
            e = sb.pop_front();
            chk("state", mgr_state, e.st);
            chk("pll_rst", pll_rst, e.prst);
            chk("eth_rst_n", eth_rst_n, e.erst);
            chk("lock_ok", lock_ok, e.lok);
            chk("loss_count", loss_count, e.loss);
            chk("retry_count", retry_count, e.retry);
        end
    endtask

    task automatic run_until(input logic [1:0] s, input int budget, input string tag, output int n);
        n = 0;
        while (mgr_state !== s && n < budget) begin
            tick();
            n++;
        end
        if (mgr_state !== s) chk(tag, mgr_state, s);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_state"}, mgr_state, 0);
        chk({tag, "_pll_rst"}, pll_rst, 1);
        chk({tag, "_eth_rst_n"}, eth_rst_n, 0);
        chk({tag, "_lock_ok"}, lock_ok, 0);
        chk({tag, "_loss"}, loss_count, 0);
        chk({tag, "_retry"}, retry_count, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int prst_hi;
        bit seen_wait;
        bit eth_hi;

        rst_n = 1'b1; pll_locked = 1'b0; force_relock = 1'b0;
        model_reset();
        #1 rst_n = 1'b0;
        #1 chk_reset_outs("por");
        tick(); tick();
        rst_n = 1'b1;

        // Bring-up: lock pin rises at cycle 10
        prst_hi = 0;
        for (int i = 0; i < 10; i++) begin
            if (pll_rst) prst_hi++;
            tick();
        end
        chk("prst_len", prst_hi, RST);
        pll_locked = 1'b1;
        run_until(2'd2, 20, "to_stable", n);
        chk("stable_lat", n, 3);
        run_until(2'd3, 20, "to_run", n);
        chk("run_lat", n, STB);
        chk("lock_ok_run", lock_ok, 1);

        // One-cycle lock drop in RUN
        pll_locked = 1'b0;
        tick();
        pll_locked = 1'b1;
        n = 1;
        while (!pll_rst && n < 10) begin
            tick();
            n++;
        end
        chk("loss_lat", n, 3);
        chk("loss_after_drop", loss_count, ecnt(1));
        run_until(2'd3, 100, "reacq", n);

        // Relock request in RUN with lock held, then a 2-cycle glitch in STABLE
        force_relock = 1'b1;
        tick();
        force_relock = 1'b0;
        chk("force_run_state", mgr_state, 0);
        run_until(2'd2, 100, "to_stable2", n);
        seen_wait = 0; eth_hi = 0;
        for (int i = 0; i < 10; i++) begin
            pll_locked = !(i == 2 || i == 3);
            tick();
            if (mgr_state == 2'd1) seen_wait = 1;
            if (eth_rst_n) eth_hi = 1;
        end
        chk("glitch_wait", seen_wait, 1);
        chk("glitch_eth", eth_hi, 0);
        chk("glitch_loss", loss_count, ecnt(1));
        chk("glitch_retry", retry_count, ecnt(0));
        run_until(2'd3, 100, "reacq2", n);

        // Relock request coincident with a synchronized lock drop
        pll_locked = 1'b0;
        tick(); tick();
        force_relock = 1'b1;
        tick();
        force_relock = 1'b0;
        chk("force_drop_state", mgr_state, 0);
        chk("force_drop_loss", loss_count, ecnt(2));

        // Relock request during PLL reset must not stretch the pulse
        n = 0;
        while (pll_rst && n < 20) begin
            n++;
            force_relock = (n == 2);
            tick();
        end
        force_relock = 1'b0;
        chk("prst_force_len", n, RST);

        // Timeout loop with lock held low
        for (int i = 0; i < TO + 2 * (RST + TO); i++) tick();
        chk("retry3", retry_count, ecnt(3));
        chk("retry3_state", mgr_state, 0);
        for (int i = 0; i < 300 * (RST + TO); i++) tick();
        chk("retry_sat", retry_count, ecnt(255));

        // Asynchronous reset mid-STABLE
        pll_locked = 1'b1;
        run_until(2'd2, 200, "to_stable3", n);
        tick(); tick();
        #1 rst_n = 1'b0;
        model_reset();
        #1 chk_reset_outs("async");
        tick(); tick();
        rst_n = 1'b1;
        run_until(2'd3, 100, "reacq3", n);
        chk("final_loss", loss_count, ecnt(0));
        chk("final_retry", retry_count, ecnt(0));

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
